multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle controller that sequences the shared single-ALU/single-memory MIPS datapath, one instruction per several cycles.
- Supported opcodes: R-type, ori, addi, j, beq, lw, sw.
- Sits between the instruction register (supplies Op_i) and the datapath muxes, ALU control, register file and unified memory port.
- Stalls on a memory ready handshake and flags illegal opcodes.

Parameters:
- STATE_W, 4, width of state register and state_o.
- CNT_W, 32, width of performance counters (only with MC_CTRL_PERF_EN).

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous active-high reset
- Op_i  in  6  opcode from IR; stable from DECODE onward
- Zero_i  in  1  ALU zero flag
- mem_ready_i  in  1  memory completes the current access this cycle
- PCWrite_o  out  1  PC load enable
- PCSrc_o  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
- IorD_o  out  1  memory address: 0 PC, 1 ALUOut
- MemRead_o  out  1  memory read request
- MemWrite_o  out  1  memory write request
- IRWrite_o  out  1  IR load enable
- RegDst_o  out  1  write register: 1 rd, 0 rt
- MemtoReg_o  out  1  writeback source: 1 MDR, 0 ALUOut
- RegWrite_o  out  1  register file write enable
- ALUSrcA_o  out  1  0 PC, 1 rs
- ALUSrcB_o  out  2  00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2
- ALUOp_o  out  2  00 add, 01 sub, 10 or, 11 funct-decoded
- ExtOp_o  out  1  1 sign-extend, 0 zero-extend
- retire_o  out  1  one-cycle pulse on the final cycle of each instruction
- illegal_o  out  1  one-cycle pulse in DECODE on an unsupported opcode
- state_o  out  STATE_W  current state, for debug

Behaviour:
- Outputs are combinational from state, Op_i, Zero_i and mem_ready_i. Every output not listed for a state is 0; there are no latches.
- While rst_i=1, all outputs are 0. Any clock edge with rst_i=1 sets state to FETCH, including mid-instruction; pending memory access is abandoned.
- FETCH(0):
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite=PCWrite=mem_ready_i.
  - Stay in FETCH until mem_ready_i, then go to DECODE.
- DECODE(1):
  - ALUSrcA=0, ALUSrcB=11, ALUOp=00, ExtOp=1 (branch target into ALUOut).
  - Next state by Op_i:
    - lw/sw go to MEMADR.
    - R-type goes to RTEX.
    - addi/ori go to ITEX.
    - beq goes to BRANCH.
    - j goes to JUMP.
    - Any other opcode goes to FETCH with illegal_o=1.
- MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00, ExtOp=1. lw goes to MEMRD; sw goes to MEMWR.
- MEMRD(3): IorD=1, MemRead=1. Hold until mem_ready_i, then go to MEMWB.
- MEMWB(4): RegDst=0, MemtoReg=1, RegWrite=1, retire_o=1. Then FETCH.
- MEMWR(5): IorD=1, MemWrite=1, held until mem_ready_i. retire_o=mem_ready_i. Then FETCH.
- RTEX(6): ALUSrcA=1, ALUSrcB=00, ALUOp=11. Then ALUWB.
- ITEX(7): ALUSrcA=1, ALUSrcB=10. For addi: ALUOp=00, ExtOp=1. For ori: ALUOp=10, ExtOp=0. Then ALUWB.
- ALUWB(8): RegWrite=1, MemtoReg=0, RegDst=1 iff Op_i is R-type, retire_o=1. Then FETCH.
- BRANCH(9): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, PCWrite=Zero_i, retire_o=1. Then FETCH.
- JUMP(10): PCSrc=10, PCWrite=1, retire_o=1. Then FETCH.
- Unused state codes 11-15 go to FETCH on the next edge; outputs are 0.
- Minimum latency in cycles (mem_ready_i tied 1): lw 5, sw 4, R/addi/ori 4, beq 3, j 3. Each memory wait cycle adds 1.
- mem_ready_i is ignored outside FETCH/MEMRD/MEMWR.

Optional Feature:
- MC_CTRL_PERF_EN defined: adds outputs cycle_cnt_o[CNT_W] and instr_cnt_o[CNT_W].
  - Both are 0 on reset.
  - cycle_cnt_o increments every non-reset cycle.
  - instr_cnt_o increments on each retire_o.
  - Both wrap modulo 2^CNT_W.
- Undefined: those ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package mc_ctrl_pkg:
  - Opcode constants (R_TYPE 000000, ORI 001101, ADDI 001000, J 000010, BEQ 000100, LW 100011, SW 101011).
  - State encodings 0-10.
  - ALUOp, PCSrc and ALUSrcB encodings.
- One sub-module, mc_ctrl_outdec: combinational state/Op_i/Zero_i/mem_ready_i to control-word decode. The top module holds the state register, next-state logic and counters.

Test Plan:
- Reset mid-MEMRD (rst_i=1 one edge) -> state_o=0 next cycle; all outputs 0 while rst_i=1; FETCH outputs after release.
- lw, mem_ready_i=1 -> states 0,1,2,3,4; RegWrite=1 and MemtoReg=1 only in state 4; retire_o pulses once; 5 cycles.
- sw with mem_ready_i low 3 cycles in MEMWR -> MemWrite=1 held 4 cycles; retire_o only on the ready cycle.
- beq Zero_i=1 then Zero_i=0 -> PCWrite=1 with PCSrc=01 in BRANCH, then PCWrite=0; 3 cycles each.
- ori then addi -> ITEX shows ALUOp=10/ExtOp=0, then ALUOp=00/ExtOp=1; ALUWB RegDst=0; R-type ALUWB RegDst=1.
- Op_i=111111 -> illegal_o=1 for one cycle in DECODE, return to FETCH, no RegWrite/MemWrite/PCWrite beyond FETCH; with MC_CTRL_PERF_EN, instr_cnt_o unchanged.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS controller: opcodes, state codes
// and the encodings of the ALUOp, PCSrc and ALUSrcB select fields.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_R_TYPE = 6'b000000;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_ITEX   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_OR    = 2'b10;
    localparam logic [1:0] ALU_FUNCT = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    function automatic logic is_legal_op(input logic [5:0] op);
        case (op)
            OP_R_TYPE, OP_ORI, OP_ADDI, OP_J, OP_BEQ, OP_LW, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational control-word decode: current state plus Op_i, Zero_i and
// mem_ready_i to every datapath control line. All lines are held low in reset.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  logic       rst,
    input  logic [3:0] state,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       ext_op,
    output logic       retire,
    output logic       illegal
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path through
        // this block leaves a signal unassigned, which would infer a latch.
        pc_write   = 1'b0;
        pc_src     = PC_ALU;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        alu_op     = ALU_ADD;
        ext_op     = 1'b0;
        retire     = 1'b0;
        illegal    = 1'b0;
        if (!rst) begin
            case (state_t'(state))
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    // Branch target is computed speculatively into ALUOut.
                    alu_src_b = SRCB_IMM_SH2;
                    ext_op    = 1'b1;
                    illegal   = !is_legal_op(op);
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    ext_op    = 1'b1;
                end
                S_MEMRD: begin
                    iord     = 1'b1;
                    mem_read = 1'b1;
                end
                S_MEMWB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                    retire     = 1'b1;
                end
                S_MEMWR: begin
                    iord      = 1'b1;
                    mem_write = 1'b1;
                    retire    = mem_ready;
                end
                S_RTEX: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_FUNCT;
                end
                S_ITEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    if (op == OP_ORI) begin
                        alu_op = ALU_OR;
                    end else begin
                        ext_op = 1'b1;
                    end
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    reg_dst   = (op == OP_R_TYPE);
                    retire    = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_SUB;
                    pc_src    = PC_ALUOUT;
                    pc_write  = zero;
                    retire    = 1'b1;
                end
                S_JUMP: begin
                    pc_src   = PC_JUMP;
                    pc_write = 1'b1;
                    retire   = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS controller: state register, next-state logic and optional
// performance counters (enabled by defining MC_CTRL_PERF_EN).
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
`ifdef MC_CTRL_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
)
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [5:0]         Op_i,
    input  logic               Zero_i,
    input  logic               mem_ready_i,
    output logic               PCWrite_o,
    output logic [1:0]         PCSrc_o,
    output logic               IorD_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic               IRWrite_o,
    output logic               RegDst_o,
    output logic               MemtoReg_o,
    output logic               RegWrite_o,
    output logic               ALUSrcA_o,
    output logic [1:0]         ALUSrcB_o,
    output logic [1:0]         ALUOp_o,
    output logic               ExtOp_o,
    output logic               retire_o,
    output logic               illegal_o,
    output logic [STATE_W-1:0] state_o
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]   cycle_cnt_o,
    output logic [CNT_W-1:0]   instr_cnt_o
`endif
);

    state_t state_q;
    state_t state_d;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op_i)
                    OP_LW, OP_SW:     state_d = S_MEMADR;
                    OP_R_TYPE:        state_d = S_RTEX;
                    OP_ADDI, OP_ORI:  state_d = S_ITEX;
                    OP_BEQ:           state_d = S_BRANCH;
                    OP_J:             state_d = S_JUMP;
                    default:          state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (Op_i == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_ready_i ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_ready_i ? S_FETCH : S_MEMWR;
            S_RTEX:   state_d = S_ALUWB;
            S_ITEX:   state_d = S_ALUWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of block ordering.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = rst_i ? '0 : STATE_W'(state_q);

    mc_ctrl_outdec u_outdec (
        .rst        (rst_i),
        .state      (state_q),
        .op         (Op_i),
        .zero       (Zero_i),
        .mem_ready  (mem_ready_i),
        .pc_write   (PCWrite_o),
        .pc_src     (PCSrc_o),
        .iord       (IorD_o),
        .mem_read   (MemRead_o),
        .mem_write  (MemWrite_o),
        .ir_write   (IRWrite_o),
        .reg_dst    (RegDst_o),
        .mem_to_reg (MemtoReg_o),
        .reg_write  (RegWrite_o),
        .alu_src_a  (ALUSrcA_o),
        .alu_src_b  (ALUSrcB_o),
        .alu_op     (ALUOp_o),
        .ext_op     (ExtOp_o),
        .retire     (retire_o),
        .illegal    (illegal_o)
    );

`ifdef MC_CTRL_PERF_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_cnt_o <= '0;
            instr_cnt_o <= '0;
        end else begin
            cycle_cnt_o <= cycle_cnt_o + CNT_W'(1);
            if (retire_o) begin
                instr_cnt_o <= instr_cnt_o + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed vector table, reset corner case and
// random instruction stream checked against a per-opcode step-plan model.
module tb_multicycle_control;

    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] ORI  = 6'b001101;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic       zero;
    logic       rdy;

    logic       pc_write, iord, mem_read, mem_write, ir_write, reg_dst;
    logic       mem_to_reg, reg_write, alu_src_a, ext_op, retire, illegal;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic [3:0] st_o;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .Op_i        (op),
        .Zero_i      (zero),
        .mem_ready_i (rdy),
        .PCWrite_o   (pc_write),
        .PCSrc_o     (pc_src),
        .IorD_o      (iord),
        .MemRead_o   (mem_read),
        .MemWrite_o  (mem_write),
        .IRWrite_o   (ir_write),
        .RegDst_o    (reg_dst),
        .MemtoReg_o  (mem_to_reg),
        .RegWrite_o  (reg_write),
        .ALUSrcA_o   (alu_src_a),
        .ALUSrcB_o   (alu_src_b),
        .ALUOp_o     (alu_op),
        .ExtOp_o     (ext_op),
        .retire_o    (retire),
        .illegal_o   (illegal),
        .state_o     (st_o)
`ifdef MC_CTRL_PERF_EN
        ,
        .cycle_cnt_o (cycle_cnt),
        .instr_cnt_o (instr_cnt)
`endif
    );

    typedef struct packed {
        logic [3:0] state;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       ext_op;
        logic       retire;
        logic       illegal;
    } word_t;

    word_t act;
    assign act = {st_o, pc_write, pc_src, iord, mem_read, mem_write, ir_write, reg_dst,
                  mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, ext_op, retire, illegal};

    typedef struct {
        logic [5:0] op;
        logic       z;
        logic       r;
        int         st;
        logic       ret;
        logic       pcw;
        logic       rw;
        logic       mw;
        logic       ill;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;
    int   n_cyc = 0;
    int   n_instr = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    function automatic logic legal(input logic [5:0] o);
        return o inside {RT, ORI, ADDI, JMP, BEQ, LW, SW};
    endfunction

    // Expected control word for a given state, straight from the state table.
    function automatic word_t ref_word(input int st, input logic [5:0] o, input logic z, input logic r);
        word_t w;
        w = '0;
        w.state = st[3:0];
        case (st)
            0:  begin w.mem_read = 1; w.alu_src_b = 2'b01; w.ir_write = r; w.pc_write = r; end
            1:  begin w.alu_src_b = 2'b11; w.ext_op = 1; w.illegal = !legal(o); end
            2:  begin w.alu_src_a = 1; w.alu_src_b = 2'b10; w.ext_op = 1; end
            3:  begin w.iord = 1; w.mem_read = 1; end
            4:  begin w.mem_to_reg = 1; w.reg_write = 1; w.retire = 1; end
            5:  begin w.iord = 1; w.mem_write = 1; w.retire = r; end
            6:  begin w.alu_src_a = 1; w.alu_op = 2'b11; end
            7:  begin
                    w.alu_src_a = 1; w.alu_src_b = 2'b10;
                    if (o == ORI) w.alu_op = 2'b10;
                    else w.ext_op = 1;
                end
            8:  begin w.reg_write = 1; w.reg_dst = (o == RT); w.retire = 1; end
            9:  begin w.alu_src_a = 1; w.alu_op = 2'b01; w.pc_src = 2'b01; w.pc_write = z; w.retire = 1; end
            10: begin w.pc_src = 2'b10; w.pc_write = 1; w.retire = 1; end
            default: ;
        endcase
        return w;
    endfunction

    task automatic add(input logic [5:0] o, input logic z, input logic r, input int st,
                       input logic ret, input logic pcw, input logic rw, input logic mw,
                       input logic ill);
        vec_t v;
        v.op = o; v.z = z; v.r = r; v.st = st;
        v.ret = ret; v.pcw = pcw; v.rw = rw; v.mw = mw; v.ill = ill;
        tbl.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            n_cyc = 0;
            n_instr = 0;
        end else begin
            n_cyc++;
        end
        #1;
    endtask

    task automatic check_perf(input string name);
`ifdef MC_CTRL_PERF_EN
        check({name, " cycle_cnt"}, cycle_cnt, n_cyc);
        check({name, " instr_cnt"}, instr_cnt, n_instr);
`endif
    endtask

    initial begin
        word_t   exp_w;
        int      plan[$];
        int      idx;
        int      waits;
        logic [5:0] o;
        logic    z;
        logic    r;
        logic [5:0] ops[7];

        ops = '{RT, ORI, ADDI, JMP, BEQ, LW, SW};

        //      op    z  r  st ret pcw rw mw ill
        add(LW,   0, 1, 0,  0, 1,  0, 0, 0);
        add(LW,   0, 0, 1,  0, 0,  0, 0, 0);
        add(LW,   0, 0, 2,  0, 0,  0, 0, 0);
        add(LW,   0, 1, 3,  0, 0,  0, 0, 0);
        add(LW,   0, 0, 4,  1, 0,  1, 0, 0);
        add(SW,   0, 0, 0,  0, 0,  0, 0, 0);
        add(SW,   0, 1, 0,  0, 1,  0, 0, 0);
        add(SW,   0, 1, 1,  0, 0,  0, 0, 0);
        add(SW,   0, 1, 2,  0, 0,  0, 0, 0);
        add(SW,   0, 0, 5,  0, 0,  0, 1, 0);
        add(SW,   0, 0, 5,  0, 0,  0, 1, 0);
        add(SW,   0, 0, 5,  0, 0,  0, 1, 0);
        add(SW,   0, 1, 5,  1, 0,  0, 1, 0);
        add(BEQ,  1, 1, 0,  0, 1,  0, 0, 0);
        add(BEQ,  1, 1, 1,  0, 0,  0, 0, 0);
        add(BEQ,  1, 1, 9,  1, 1,  0, 0, 0);
        add(BEQ,  0, 1, 0,  0, 1,  0, 0, 0);
        add(BEQ,  0, 1, 1,  0, 0,  0, 0, 0);
        add(BEQ,  0, 1, 9,  1, 0,  0, 0, 0);
        add(ORI,  0, 1, 0,  0, 1,  0, 0, 0);
        add(ORI,  0, 1, 1,  0, 0,  0, 0, 0);
        add(ORI,  0, 1, 7,  0, 0,  0, 0, 0);
        add(ORI,  0, 1, 8,  1, 0,  1, 0, 0);
        add(ADDI, 0, 1, 0,  0, 1,  0, 0, 0);
        add(ADDI, 0, 1, 1,  0, 0,  0, 0, 0);
        add(ADDI, 0, 1, 7,  0, 0,  0, 0, 0);
        add(ADDI, 0, 1, 8,  1, 0,  1, 0, 0);
        add(RT,   0, 1, 0,  0, 1,  0, 0, 0);
        add(RT,   0, 1, 1,  0, 0,  0, 0, 0);
        add(RT,   0, 1, 6,  0, 0,  0, 0, 0);
        add(RT,   0, 1, 8,  1, 0,  1, 0, 0);
        add(BAD,  0, 1, 0,  0, 1,  0, 0, 0);
        add(BAD,  0, 1, 1,  0, 0,  0, 0, 1);
        add(JMP,  0, 1, 0,  0, 1,  0, 0, 0);
        add(JMP,  0, 1, 1,  0, 0,  0, 0, 0);
        add(JMP,  0, 0, 10, 1, 1,  0, 0, 0);

        rst = 1'b1; op = LW; zero = 1'b1; rdy = 1'b1;
        tick();
        tick();
        #4;
        check("outputs in reset", act, 32'h0);
        tick();
        rst = 1'b0;

        foreach (tbl[i]) begin
            op = tbl[i].op; zero = tbl[i].z; rdy = tbl[i].r;
            #4;
            exp_w = ref_word(tbl[i].st, tbl[i].op, tbl[i].z, tbl[i].r);
            check($sformatf("vec%0d word", i), act, exp_w);
            check($sformatf("vec%0d key", i),
                  {st_o, retire, pc_write, reg_write, mem_write, illegal},
                  {tbl[i].st[3:0], tbl[i].ret, tbl[i].pcw, tbl[i].rw, tbl[i].mw, tbl[i].ill});
            if (exp_w.retire) n_instr++;
            tick();
        end
        check_perf("after table");

        // lw interrupted by reset while waiting in MEMRD
        op = LW; rdy = 1'b1; zero = 1'b0;
        tick();
        tick();
        tick();
        rdy = 1'b0;
        #4;
        check("memrd before reset", act, ref_word(3, LW, 1'b0, 1'b0));
        tick();
        rst = 1'b1;
        #4;
        check("reset asserted in memrd", act, 32'h0);
        tick();
        rdy = 1'b1;
        #4;
        check("reset held", act, 32'h0);
        tick();
        rst = 1'b0; rdy = 1'b0;
        #4;
        check("fetch after reset", act, ref_word(0, LW, 1'b0, 1'b0));
        check_perf("after reset");
        tick();

        // Random instruction stream against a per-opcode list of steps.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 7) o = 6'($urandom);
            else o = ops[$urandom_range(0, 6)];
            plan.delete();
            plan.push_back(0);
            plan.push_back(1);
            case (o)
                LW:        begin plan.push_back(2); plan.push_back(3); plan.push_back(4); end
                SW:        begin plan.push_back(2); plan.push_back(5); end
                RT:        begin plan.push_back(6); plan.push_back(8); end
                ADDI, ORI: begin plan.push_back(7); plan.push_back(8); end
                BEQ:       plan.push_back(9);
                JMP:       plan.push_back(10);
                default:   ;
            endcase
            idx = 0;
            waits = 0;
            while (idx < plan.size()) begin
                z = 1'($urandom);
                r = (waits >= 6) ? 1'b1 : ($urandom_range(0, 2) != 0);
                op = o; zero = z; rdy = r;
                #4;
                exp_w = ref_word(plan[idx], o, z, r);
                check($sformatf("rand%0d op%h step%0d", n, o, idx), act, exp_w);
                if (exp_w.retire) n_instr++;
                if ((plan[idx] == 0 || plan[idx] == 3 || plan[idx] == 5) && !r) begin
                    waits++;
                end else begin
                    idx++;
                    waits = 0;
                end
                tick();
            end
        end
        #4;
        check("random end state", act, ref_word(0, op, zero, rdy));
        check_perf("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
